// File: rtl/uart_msg_tx_if.sv
// Handshake and serial-line bundle between the control FSM and the message transmitter.
interface uart_msg_tx_if #(
  parameter int unsigned M = 128,
  parameter int unsigned N = 8
);
  localparam int unsigned C  = M / N;
  localparam int unsigned LW = $clog2(C + 1);

  logic          start;
  logic [M-1:0]  msg;
  logic [LW-1:0] len;
  logic          txd;
  logic          busy;
  logic          done;
  logic [LW-1:0] char_idx;

  modport master (output start, msg, len, input txd, busy, done, char_idx);
  modport slave  (input start, msg, len, output txd, busy, done, char_idx);
endinterface

// File: rtl/uart_msg_tx.sv
// Latches a message of up to M/N characters and sends each one as a UART frame,
// most-significant character first, with optional parity and 1 or 2 stop bits.
module uart_msg_tx #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned N            = 8,
  parameter int unsigned M            = 128,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic         clk,
  input  logic         reset,
  uart_msg_tx_if.slave bus
);
  localparam int unsigned C  = M / N;
  localparam int unsigned LW = $clog2(C + 1);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_NEXT, S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [M-1:0]  buf_q, buf_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic          txd_q, txd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [LW-1:0] char_idx_q, char_idx_d;

  logic          cnt_last_c;
  logic [N-1:0]  cur_char_c;
  logic          par_bit_c;
  logic [LW-1:0] len_clamp_c;
  logic [LW-1:0] idx_inc_c;

  assign cnt_last_c  = (cnt_q == CW'(CLKS_PER_BIT - 1));
  assign cur_char_c  = buf_q[M-1 -: N];
  assign par_bit_c   = (^cur_char_c) ^ (PARITY == 32'd2);
  assign len_clamp_c = (bus.len > LW'(C)) ? LW'(C) : bus.len;
  assign idx_inc_c   = idx_q + LW'(1);

  // Next-state logic; line outputs are derived from the current state and lag it by one cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    bit_d      = bit_q;
    buf_d      = buf_q;
    len_d      = len_q;
    idx_d      = idx_q;
    txd_d      = 1'b1;
    busy_d     = (state_q != S_IDLE) && (state_q != S_FIN);
    done_d     = (state_q == S_FIN);
    char_idx_d = idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          buf_d = bus.msg;
          len_d = len_clamp_c;
          idx_d = '0;
          bit_d = '0;
          // An empty message still spends one busy cycle in NEXT before done.
          state_d = (len_clamp_c == '0) ? S_NEXT : S_START;
        end
      end
      S_START: begin
        txd_d = 1'b0;
        if (cnt_last_c) begin
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        txd_d = cur_char_c[bit_q];
        if (cnt_last_c) begin
          if (bit_q == BW'(N - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        txd_d = par_bit_c;
        if (cnt_last_c) begin
          bit_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_last_c) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_d   = '0;
            state_d = S_NEXT;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_NEXT: begin
        buf_d = buf_q << N;
        if ((len_q == '0) || (idx_inc_c == len_q)) begin
          idx_d   = '0;
          state_d = S_FIN;
        end else begin
          idx_d   = idx_inc_c;
          state_d = S_START;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      buf_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      char_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      buf_q      <= buf_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      char_idx_q <= char_idx_d;
    end
  end

  assign bus.txd      = txd_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.char_idx = char_idx_q;
endmodule
